// File: rtl/eq_pkg.sv
// Shared definitions for the equaliser setting controller.
//   state_e          : controller state encoding (S_INIT..S_SETTING)
//   STATE_W          : width of the state encoding
//   sat_inc/sat_dec  : saturating gain step helpers
package eq_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_INIT    = 2'd0,
        S_IDLE    = 2'd1,
        S_RUN     = 2'd2,
        S_SETTING = 2'd3
    } state_e;

    function automatic int sat_inc(input int value, input int max_value);
        return (value >= max_value) ? max_value : value + 1;
    endfunction

    function automatic int sat_dec(input int value);
        return (value <= 0) ? 0 : value - 1;
    endfunction

endpackage

// File: rtl/eq_gain_bank.sv
// Per-band equaliser gain register file.
// Ports:
//   i_clk, i_rst    : clock, asynchronous active-high reset
//   i_band          : band addressed by this cycle's edit
//   i_inc, i_dec    : step the addressed gain up / down; both together restore default
//   o_gains         : packed gains, band k at [k*GAIN_W +: GAIN_W]
//   o_gain_valid    : high for the cycle after any gain actually changed
module eq_gain_bank
    import eq_pkg::*;
#(
    parameter int NUM_BANDS    = 6,
    parameter int GAIN_W       = 4,
    parameter int GAIN_MAX     = 15,
    parameter int GAIN_DEFAULT = 8,
    parameter int BAND_W       = $clog2(NUM_BANDS)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [BAND_W-1:0]             i_band,
    input  logic                          i_inc,
    input  logic                          i_dec,
    output logic [NUM_BANDS*GAIN_W-1:0]   o_gains,
    output logic                          o_gain_valid
);

    logic [NUM_BANDS*GAIN_W-1:0] gains_d, gains_q;
    logic                        gain_valid_d, gain_valid_q;
    int                          cur_g, nxt_g;

    always_comb begin
        gains_d      = gains_q;
        gain_valid_d = 1'b0;
        cur_g        = 0;
        nxt_g        = 0;
        for (int k = 0; k < NUM_BANDS; k++) begin
            if ((BAND_W'(k) == i_band) && (i_inc || i_dec)) begin
                cur_g = int'(gains_q[k*GAIN_W +: GAIN_W]);
                if (i_inc && i_dec)
                    nxt_g = GAIN_DEFAULT;
                else if (i_inc)
                    nxt_g = sat_inc(cur_g, GAIN_MAX);
                else
                    nxt_g = sat_dec(cur_g);
                // Only a real change strobes; saturation or restoring the same value is silent.
                if (nxt_g != cur_g) begin
                    gains_d[k*GAIN_W +: GAIN_W] = GAIN_W'(nxt_g);
                    gain_valid_d                = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            gains_q      <= {NUM_BANDS{GAIN_W'(GAIN_DEFAULT)}};
            gain_valid_q <= 1'b0;
        end else begin
            gains_q      <= gains_d;
            gain_valid_q <= gain_valid_d;
        end
    end

    assign o_gains      = gains_q;
    assign o_gain_valid = gain_valid_q;

endmodule

// File: rtl/eq_setting_ctrl.sv
// Audio path control FSM: codec init handshake, DSP idle/run gating and
// key-driven editing of the per-band equaliser gains.
// Ports:
//   i_clk, i_rst                     : clock, asynchronous active-high reset
//   i_start/i_stop/i_up/i_down       : debounced single-cycle key pulses
//   i_switch                         : level, 1 = setting mode requested
//   i_init_done                      : I2C manager finished
//   o_init_start                     : I2C manager start request
//   o_dsp_en                         : DSP / record-play enable
//   o_state                          : current state encoding
//   o_band                           : selected band
//   o_gains, o_gain_valid            : packed gains and change strobe
//
// state     | meaning
// S_INIT    | waiting for codec init, o_init_start held high
// S_IDLE    | DSP off, start key enters S_RUN
// S_RUN     | DSP on, stop key returns to S_IDLE
// S_SETTING | editing band/gain; DSP follows the state we came from
module eq_setting_ctrl
    import eq_pkg::*;
#(
    parameter int NUM_BANDS    = 6,
    parameter int GAIN_W       = 4,
    parameter int GAIN_MAX     = 15,
    parameter int GAIN_DEFAULT = 8
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_start,
    input  logic                           i_stop,
    input  logic                           i_up,
    input  logic                           i_down,
    input  logic                           i_switch,
    input  logic                           i_init_done,
    output logic                           o_init_start,
    output logic                           o_dsp_en,
    output logic [STATE_W-1:0]             o_state,
    output logic [$clog2(NUM_BANDS)-1:0]   o_band,
    output logic [NUM_BANDS*GAIN_W-1:0]    o_gains,
    output logic                           o_gain_valid
);

    localparam int BAND_W = $clog2(NUM_BANDS);
    localparam logic [BAND_W-1:0] BAND_LAST = BAND_W'(NUM_BANDS - 1);

    state_e            state_d, state_q;
    state_e            ret_d, ret_q;
    logic [BAND_W-1:0] band_d, band_q;
    logic              init_start_d, init_start_q;
    logic              dsp_en_d, dsp_en_q;
    logic              gain_inc, gain_dec;

    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        band_d   = band_q;
        gain_inc = 1'b0;
        gain_dec = 1'b0;
        case (state_q)
            S_INIT: begin
                if (i_init_done) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (i_switch) begin
                    state_d = S_SETTING;
                    ret_d   = S_IDLE;
                end else if (i_start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (i_switch) begin
                    state_d = S_SETTING;
                    ret_d   = S_RUN;
                end else if (i_stop) begin
                    state_d = S_IDLE;
                end
            end
            S_SETTING: begin
                if (!i_switch) begin
                    state_d = ret_q;
                end else begin
                    // Edit targets band_q, so a simultaneous band move edits the old band.
                    gain_inc = i_up;
                    gain_dec = i_down;
                    if (i_start && !i_stop)
                        band_d = (band_q == BAND_LAST) ? '0 : band_q + 1'b1;
                    else if (i_stop && !i_start)
                        band_d = (band_q == '0) ? BAND_LAST : band_q - 1'b1;
                end
            end
            default: state_d = S_INIT;
        endcase
        init_start_d = (state_d == S_INIT);
        dsp_en_d     = (state_d == S_RUN) || ((state_d == S_SETTING) && (ret_d == S_RUN));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_INIT;
            ret_q        <= S_IDLE;
            band_q       <= '0;
            init_start_q <= 1'b1;
            dsp_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            band_q       <= band_d;
            init_start_q <= init_start_d;
            dsp_en_q     <= dsp_en_d;
        end
    end

    eq_gain_bank #(
        .NUM_BANDS    (NUM_BANDS),
        .GAIN_W       (GAIN_W),
        .GAIN_MAX     (GAIN_MAX),
        .GAIN_DEFAULT (GAIN_DEFAULT),
        .BAND_W       (BAND_W)
    ) u_gain_bank (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_band       (band_q),
        .i_inc        (gain_inc),
        .i_dec        (gain_dec),
        .o_gains      (o_gains),
        .o_gain_valid (o_gain_valid)
    );

    assign o_init_start = init_start_q;
    assign o_dsp_en     = dsp_en_q;
    assign o_state      = state_q;
    assign o_band       = band_q;

endmodule

// File: tb/tb_eq_setting_ctrl.sv
module tb_eq_setting_ctrl;

    localparam int NB   = 6;
    localparam int GW   = 4;
    localparam int GMAX = 15;
    localparam int GDEF = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              k_start = 0, k_stop = 0, k_up = 0, k_down = 0, sw = 0, init_done = 0;
    logic              init_start, dsp_en, gain_valid;
    logic [1:0]        state;
    logic [2:0]        band;
    logic [NB*GW-1:0]  gains;

    int checks = 0;
    int errors = 0;

    // Reference model: plain integers and an array of gains
    int m_state, m_ret, m_band, m_valid;
    int m_gains[NB];

    eq_setting_ctrl #(.NUM_BANDS(NB), .GAIN_W(GW), .GAIN_MAX(GMAX), .GAIN_DEFAULT(GDEF)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (k_start),
        .i_stop       (k_stop),
        .i_up         (k_up),
        .i_down       (k_down),
        .i_switch     (sw),
        .i_init_done  (init_done),
        .o_init_start (init_start),
        .o_dsp_en     (dsp_en),
        .o_state      (state),
        .o_band       (band),
        .o_gains      (gains),
        .o_gain_valid (gain_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic s, p, u, d, w, idn;
        int   e_state, e_dsp, e_init, e_band, e_gain0, e_valid;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int gain_of(input int k);
        return int'(gains[k*GW +: GW]);
    endfunction

    task automatic model_reset();
        m_state = 0; m_ret = 1; m_band = 0; m_valid = 0;
        for (int k = 0; k < NB; k++) m_gains[k] = GDEF;
    endtask

    task automatic model_step(input logic s, input logic p, input logic u, input logic d,
                              input logic w, input logic idn);
        int g, ng;
        m_valid = 0;
        case (m_state)
            0: if (idn) m_state = 1;
            1: if (w) begin m_ret = 1; m_state = 3; end else if (s) m_state = 2;
            2: if (w) begin m_ret = 2; m_state = 3; end else if (p) m_state = 1;
            default: begin
                if (!w) m_state = m_ret;
                else begin
                    g = m_gains[m_band];
                    if (u && d) ng = GDEF;
                    else if (u) ng = (g + 1 > GMAX) ? GMAX : g + 1;
                    else if (d) ng = (g - 1 < 0) ? 0 : g - 1;
                    else ng = g;
                    if (ng != g) begin m_gains[m_band] = ng; m_valid = 1; end
                    if (s && !p) m_band = (m_band + 1) % NB;
                    if (p && !s) m_band = (m_band + NB - 1) % NB;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        int e_dsp;
        e_dsp = (m_state == 2 || (m_state == 3 && m_ret == 2)) ? 1 : 0;
        chk("model_state", int'(state), m_state);
        chk("model_init_start", int'(init_start), (m_state == 0) ? 1 : 0);
        chk("model_dsp_en", int'(dsp_en), e_dsp);
        chk("model_band", int'(band), m_band);
        chk("model_valid", int'(gain_valid), m_valid);
        for (int k = 0; k < NB; k++) chk("model_gain", gain_of(k), m_gains[k]);
    endtask

    task automatic cycle(input logic s, input logic p, input logic u, input logic d,
                         input logic w, input logic idn);
        k_start = s; k_stop = p; k_up = u; k_down = d; sw = w; init_done = idn;
        @(posedge clk);
        #1;
        model_step(s, p, u, d, w, idn);
        compare_all();
    endtask

    vec_t vt[12];
    int   cnt, all_dsp;

    initial begin
        vt[0]  = '{s:0,p:0,u:0,d:0,w:0,idn:0, e_state:0,e_dsp:0,e_init:1,e_band:0,e_gain0:8,e_valid:0};
        vt[1]  = '{s:0,p:0,u:0,d:0,w:0,idn:1, e_state:1,e_dsp:0,e_init:0,e_band:0,e_gain0:8,e_valid:0};
        vt[2]  = '{s:0,p:0,u:1,d:0,w:0,idn:0, e_state:1,e_dsp:0,e_init:0,e_band:0,e_gain0:8,e_valid:0};
        vt[3]  = '{s:1,p:0,u:0,d:0,w:0,idn:0, e_state:2,e_dsp:1,e_init:0,e_band:0,e_gain0:8,e_valid:0};
        vt[4]  = '{s:0,p:0,u:0,d:0,w:1,idn:0, e_state:3,e_dsp:1,e_init:0,e_band:0,e_gain0:8,e_valid:0};
        vt[5]  = '{s:0,p:0,u:1,d:0,w:1,idn:0, e_state:3,e_dsp:1,e_init:0,e_band:0,e_gain0:9,e_valid:1};
        vt[6]  = '{s:0,p:1,u:0,d:0,w:1,idn:0, e_state:3,e_dsp:1,e_init:0,e_band:5,e_gain0:9,e_valid:0};
        vt[7]  = '{s:1,p:0,u:0,d:0,w:1,idn:0, e_state:3,e_dsp:1,e_init:0,e_band:0,e_gain0:9,e_valid:0};
        vt[8]  = '{s:0,p:0,u:1,d:1,w:1,idn:0, e_state:3,e_dsp:1,e_init:0,e_band:0,e_gain0:8,e_valid:1};
        vt[9]  = '{s:0,p:0,u:1,d:1,w:1,idn:0, e_state:3,e_dsp:1,e_init:0,e_band:0,e_gain0:8,e_valid:0};
        vt[10] = '{s:0,p:0,u:1,d:0,w:0,idn:0, e_state:2,e_dsp:1,e_init:0,e_band:0,e_gain0:8,e_valid:0};
        vt[11] = '{s:0,p:1,u:0,d:0,w:0,idn:0, e_state:1,e_dsp:0,e_init:0,e_band:0,e_gain0:8,e_valid:0};

        // Reset values
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst = 0;

        // Init handshake held off for 10 cycles
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 0, 0);

        // Directed table
        for (int i = 0; i < 12; i++) begin
            cycle(vt[i].s, vt[i].p, vt[i].u, vt[i].d, vt[i].w, vt[i].idn);
            chk("tbl_state", int'(state), vt[i].e_state);
            chk("tbl_dsp_en", int'(dsp_en), vt[i].e_dsp);
            chk("tbl_init_start", int'(init_start), vt[i].e_init);
            chk("tbl_band", int'(band), vt[i].e_band);
            chk("tbl_gain0", gain_of(0), vt[i].e_gain0);
            chk("tbl_valid", int'(gain_valid), vt[i].e_valid);
        end

        // Saturation from RUN: 9 ups, 20 downs, restore
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        cnt = 0; all_dsp = 1;
        for (int i = 0; i < 9; i++) begin
            cycle(0, 0, 1, 0, 1, 0);
            cnt += int'(gain_valid);
            if (!dsp_en) all_dsp = 0;
        end
        chk("up_strobes", cnt, 7);
        chk("up_gain0", gain_of(0), 15);
        chk("up_dsp_live", all_dsp, 1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(0, 0, 0, 1, 1, 0);
            cnt += int'(gain_valid);
        end
        chk("down_strobes", cnt, 15);
        chk("down_gain0", gain_of(0), 0);
        cycle(0, 0, 1, 1, 1, 0);
        chk("restore_gain0", gain_of(0), 8);
        chk("restore_strobe", int'(gain_valid), 1);

        // Band wrap and edit-on-old-band
        cycle(0, 1, 0, 0, 1, 0);
        chk("wrap_down", int'(band), 5);
        cycle(1, 0, 0, 0, 1, 0);
        chk("wrap_up", int'(band), 0);
        cycle(1, 0, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 1, 0);
        cycle(1, 0, 1, 0, 1, 0);
        chk("old_band_gain2", gain_of(2), 9);
        chk("old_band_gain3", gain_of(3), 8);
        chk("old_band_move", int'(band), 3);

        // Leaving setting ignores keys; re-entry keeps band/gains
        cycle(0, 0, 1, 0, 0, 0);
        chk("exit_state", int'(state), 2);
        chk("exit_gain3", gain_of(3), 8);
        chk("exit_valid", int'(gain_valid), 0);
        cycle(0, 0, 0, 0, 1, 0);
        chk("reenter_band", int'(band), 3);
        chk("reenter_gain2", gain_of(2), 9);

        // Asynchronous reset mid-setting
        rst = 1;
        #2;
        model_reset();
        compare_all();
        chk("arst_gain2", gain_of(2), 8);
        chk("arst_state", int'(state), 0);
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 0);
        chk("reinit_hold", int'(init_start), 1);
        cycle(0, 0, 0, 0, 1, 1);
        chk("reinit_done", int'(state), 1);
        chk("reinit_drop", int'(init_start), 0);

        // Random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            logic w;
            w = sw;
            if ($urandom_range(0, 15) == 0) w = ~w;
            cycle(logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 3) == 0),
                  logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 2) == 0),
                  w, logic'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
